// File: rtl/cpc_ram_pkg.sv
// rtl/cpc_ram_pkg.sv - shared types, block map table and bank width helper
package cpc_ram_pkg;

  typedef enum logic {
    ST_ARMED        = 1'b0,
    ST_WAIT_RELEASE = 1'b1
  } cap_state_e;

  // Indexed [cfg][quadrant]; entries are listed from cfg 7 down to 0, quadrant 3 down to 0.
  localparam logic [7:0][3:0][2:0] BLOCK_MAP = {
    {3'd3, 3'd2, 3'd7, 3'd0},
    {3'd3, 3'd2, 3'd6, 3'd0},
    {3'd3, 3'd2, 3'd5, 3'd0},
    {3'd3, 3'd2, 3'd4, 3'd0},
    {3'd7, 3'd2, 3'd3, 3'd0},
    {3'd7, 3'd6, 3'd5, 3'd4},
    {3'd7, 3'd2, 3'd1, 3'd0},
    {3'd3, 3'd2, 3'd1, 3'd0}
  };

  function automatic int bank_w(input int num_sram);
    return 3 + $clog2(num_sram);
  endfunction

endpackage

// File: rtl/cpc_ram_bank_ctrl_if.sv
// rtl/cpc_ram_bank_ctrl_if.sv - Z80 bus side and SRAM control side signals
interface cpc_ram_bank_ctrl_if #(
  parameter int NUM_SRAM = 2
);

  logic [15:0]         adr;
  logic [7:0]          data;
  logic                mreq_b;
  logic                ioreq_b;
  logic                rd_b;
  logic                wr_b;
  logic                m1_b;
  logic                rfsh_b;
  logic                dip_en;
  logic [4:0]          hiadr;
  logic [NUM_SRAM-1:0] ramcs_b;
  logic                ramoe_b;
  logic                ramwe_b;
  logic                ramdis;

  modport master (
    output adr, data, mreq_b, ioreq_b, rd_b, wr_b, m1_b, rfsh_b, dip_en,
    input  hiadr, ramcs_b, ramoe_b, ramwe_b, ramdis
  );

  modport slave (
    input  adr, data, mreq_b, ioreq_b, rd_b, wr_b, m1_b, rfsh_b, dip_en,
    output hiadr, ramcs_b, ramoe_b, ramwe_b, ramdis
  );

endinterface

// File: rtl/cpc_ram_map.sv
// rtl/cpc_ram_map.sv - combinational cfg/quadrant to 16KB block lookup
module cpc_ram_map
  import cpc_ram_pkg::*;
(
  input  logic [2:0] cfg_i,
  input  logic [1:0] quad_i,
  output logic [2:0] block_o,
  output logic       is_ext_o
);

  assign block_o  = BLOCK_MAP[cfg_i][quad_i];
  assign is_ext_o = block_o[2];

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// rtl/cpc_ram_bank_ctrl.sv - CPC RAM expansion bank controller: config capture FSM and SRAM select
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int  NUM_SRAM = 2,
  localparam int BANK_W   = bank_w(NUM_SRAM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cpc_ram_bank_ctrl_if.slave bus,
  output logic [2:0]        cfg_o,
  output logic [BANK_W-1:0] bank_o
);

  localparam int           EXT_W    = BANK_W - 3;
  localparam int           CHIP_W   = (EXT_W > 0) ? EXT_W : 1;
  localparam logic [2:0]   EXT_MASK = 3'((1 << EXT_W) - 1);

  cap_state_e        state_q, state_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] bank_new;
  logic              ext_ok;
  logic              wr_hit;
  logic [2:0]        block;
  logic              is_ext;
  logic [CHIP_W-1:0] chip_idx;
  logic              sel;
  logic              unused_adr;

  // Unused high A10..A8 lines must read 1 so smaller builds ignore ports meant for bigger ones.
  assign ext_ok = &(bus.adr[10:8] | EXT_MASK);

  assign wr_hit = !bus.ioreq_b && !bus.wr_b && bus.m1_b && !bus.adr[15]
                  && (bus.data[7:6] == 2'b11) && ext_ok;

  generate
    if (EXT_W > 0) begin : g_ext
      assign bank_new = {~bus.adr[8 +: EXT_W], bus.data[5:3]};
      assign chip_idx = bank_q[BANK_W-1:3];
    end else begin : g_noext
      assign bank_new = bus.data[5:3];
      assign chip_idx = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_WAIT_RELEASE;
      cfg_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      bank_q  <= bank_d;
    end
  end

  // One commit per I/O cycle: after capturing, wait for the strobe to drop before re-arming.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    bank_d  = bank_q;
    case (state_q)
      ST_ARMED: begin
        if (wr_hit) begin
          cfg_d   = bus.data[2:0];
          bank_d  = bank_new;
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (bus.ioreq_b || bus.wr_b) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_WAIT_RELEASE;
    endcase
  end

  cpc_ram_map u_map (
    .cfg_i    (cfg_q),
    .quad_i   (bus.adr[15:14]),
    .block_o  (block),
    .is_ext_o (is_ext)
  );

  assign sel = !bus.mreq_b && bus.rfsh_b && (!bus.rd_b || !bus.wr_b) && bus.dip_en && is_ext;

  always_comb begin
    bus.ramcs_b = '1;
    for (int i = 0; i < NUM_SRAM; i++) begin
      bus.ramcs_b[i] = !(sel && (chip_idx == CHIP_W'(i)));
    end
  end

  assign bus.hiadr   = sel ? {bank_q[2:0], block[1:0]} : 5'b0;
  assign bus.ramoe_b = sel ? bus.rd_b : 1'b1;
  assign bus.ramwe_b = sel ? bus.wr_b : 1'b1;
  assign bus.ramdis  = sel;

  assign cfg_o  = cfg_q;
  assign bank_o = bank_q;

  assign unused_adr = ^{bus.adr[13:11], bus.adr[7:0]};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// tb/tb_cpc_ram_bank_ctrl.sv - directed bench for cpc_ram_bank_ctrl with 2-SRAM and 1-SRAM builds
module tb_cpc_ram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0;
  logic [7:0]  data = '0;
  logic        mreq_b = 1'b1, ioreq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1;
  logic        m1_b = 1'b1, rfsh_b = 1'b1, dip_en = 1'b1;

  logic [2:0]  cfg2, cfg1;
  logic [3:0]  bank2;
  logic [2:0]  bank1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpc_ram_bank_ctrl_if #(.NUM_SRAM(2)) bus2 ();
  cpc_ram_bank_ctrl_if #(.NUM_SRAM(1)) bus1 ();

  assign bus2.adr = adr;      assign bus1.adr = adr;
  assign bus2.data = data;    assign bus1.data = data;
  assign bus2.mreq_b = mreq_b;   assign bus1.mreq_b = mreq_b;
  assign bus2.ioreq_b = ioreq_b; assign bus1.ioreq_b = ioreq_b;
  assign bus2.rd_b = rd_b;    assign bus1.rd_b = rd_b;
  assign bus2.wr_b = wr_b;    assign bus1.wr_b = wr_b;
  assign bus2.m1_b = m1_b;    assign bus1.m1_b = m1_b;
  assign bus2.rfsh_b = rfsh_b;   assign bus1.rfsh_b = rfsh_b;
  assign bus2.dip_en = dip_en;   assign bus1.dip_en = dip_en;

  cpc_ram_bank_ctrl #(.NUM_SRAM(2)) dut2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus2),
    .cfg_o  (cfg2),
    .bank_o (bank2)
  );

  cpc_ram_bank_ctrl #(.NUM_SRAM(1)) dut1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus1),
    .cfg_o  (cfg1),
    .bank_o (bank1)
  );

  typedef struct {
    logic [15:0] port;
    logic [7:0]  cdata;
    logic [15:0] madr;
    logic        mreq, rd, wr, rfsh, dip;
    logic [2:0]  e_cfg;
    logic [3:0]  e_bank;
    logic [4:0]  e_hiadr;
    logic [1:0]  e_cs;
    logic        e_dis, e_oe, e_we;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write_x(input logic [15:0] a, input logic [7:0] d, input logic m1);
    adr = a; data = d; m1_b = m1; ioreq_b = 1'b0; wr_b = 1'b0;
    tick();
    ioreq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    tick();
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    io_write_x(a, d, 1'b1);
  endtask

  task automatic mem_idle();
    mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; rfsh_b = 1'b1;
  endtask

  task automatic chk_idle2(input string tag);
    chk({tag, ".hiadr"}, 32'(bus2.hiadr), 32'h0);
    chk({tag, ".cs"}, 32'(bus2.ramcs_b), 32'h3);
    chk({tag, ".oe"}, 32'(bus2.ramoe_b), 32'h1);
    chk({tag, ".we"}, 32'(bus2.ramwe_b), 32'h1);
    chk({tag, ".dis"}, 32'(bus2.ramdis), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{16'h7E00, 8'hC9, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 4'd9,  5'b00111, 2'b01, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{16'h7F00, 8'hC2, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'd0,  5'b00001, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h7F00, 8'hC2, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'd0,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{16'h7F00, 8'hC3, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 4'd0,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{16'h7F00, 8'hC3, 16'hC000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0,  5'b00011, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h7E00, 8'hFE, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 4'd15, 5'b11110, 2'b01, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h7E00, 8'hFE, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 4'd15, 5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{16'h7F00, 8'hC2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd0,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{16'h7F00, 8'hEC, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 4'd5,  5'b10100, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h7F00, 8'hEC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 4'd5,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{16'h7F00, 8'hEC, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 4'd5,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{16'h7F00, 8'hEC, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 4'd5,  5'b00000, 2'b11, 1'b0, 1'b1, 1'b1};

    // Reset state
    #2;
    chk("rst.cfg", 32'(cfg2), 32'h0);
    chk("rst.bank", 32'(bank2), 32'h0);
    chk_idle2("rst");
    chk("rst.cs1", 32'(bus1.ramcs_b), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      dip_en = vecs[i].dip;
      io_write(vecs[i].port, vecs[i].cdata);
      adr = vecs[i].madr; mreq_b = vecs[i].mreq; rd_b = vecs[i].rd;
      wr_b = vecs[i].wr; rfsh_b = vecs[i].rfsh;
      #1;
      chk($sformatf("v%0d.cfg", i), 32'(cfg2), 32'(vecs[i].e_cfg));
      chk($sformatf("v%0d.bank", i), 32'(bank2), 32'(vecs[i].e_bank));
      chk($sformatf("v%0d.hiadr", i), 32'(bus2.hiadr), 32'(vecs[i].e_hiadr));
      chk($sformatf("v%0d.cs", i), 32'(bus2.ramcs_b), 32'(vecs[i].e_cs));
      chk($sformatf("v%0d.dis", i), 32'(bus2.ramdis), 32'(vecs[i].e_dis));
      chk($sformatf("v%0d.oe", i), 32'(bus2.ramoe_b), 32'(vecs[i].e_oe));
      chk($sformatf("v%0d.we", i), 32'(bus2.ramwe_b), 32'(vecs[i].e_we));
      mem_idle();
      dip_en = 1'b1;
      tick();
    end

    // Long strobe: single commit, new value visible only from the sampling edge
    adr = 16'h7F00; data = 8'hC1; ioreq_b = 1'b0; wr_b = 1'b0;
    #1;
    chk("long.pre_edge", 32'(cfg2), 32'h4);
    tick();
    chk("long.commit", 32'(cfg2), 32'h1);
    data = 8'hC2;
    repeat (4) tick();
    chk("long.held", 32'(cfg2), 32'h1);
    ioreq_b = 1'b1; wr_b = 1'b1;
    tick();
    chk("long.after", 32'(cfg2), 32'h1);

    // Rejected writes
    io_write_x(16'h7F00, 8'hC5, 1'b0);
    chk("rej.m1", 32'(cfg2), 32'h1);
    io_write(16'h7F00, 8'h85);
    chk("rej.d76", 32'(cfg2), 32'h1);
    io_write(16'hFF00, 8'hC5);
    chk("rej.a15", 32'(cfg2), 32'h1);
    io_write(16'h7F00, 8'hC5);
    chk("rej.then_ok", 32'(cfg2), 32'h5);

    // Reset mid-strobe, released while strobe still low
    adr = 16'h7F00; data = 8'hC6; ioreq_b = 1'b0; wr_b = 1'b0;
    tick();
    chk("rstmid.commit", 32'(cfg2), 32'h6);
    rst = 1'b1;
    #1;
    chk("rstmid.async_cfg", 32'(cfg2), 32'h0);
    chk("rstmid.async_bank", 32'(bank2), 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rstmid.no_commit", 32'(cfg2), 32'h0);
    chk("rstmid.no_commit1", 32'(cfg1), 32'h0);
    ioreq_b = 1'b1; wr_b = 1'b1;
    tick();
    io_write(16'h7F00, 8'hC2);
    chk("rstmid.next", 32'(cfg2), 32'h2);

    // Single-SRAM build: A8 must be 1
    io_write(16'h7E00, 8'hC1);
    chk("one.7e_ignored", 32'(cfg1), 32'h2);
    chk("two.7e_taken", 32'(cfg2), 32'h1);
    chk("two.7e_bank", 32'(bank2), 32'h8);
    io_write(16'h7F00, 8'hC1);
    chk("one.7f_cfg", 32'(cfg1), 32'h1);
    chk("one.7f_bank", 32'(bank1), 32'h0);
    adr = 16'hC000; mreq_b = 1'b0; rd_b = 1'b0;
    #1;
    chk("one.hiadr", 32'(bus1.hiadr), 32'h03);
    chk("one.cs", 32'(bus1.ramcs_b), 32'h0);
    chk("one.dis", 32'(bus1.ramdis), 32'h1);
    mem_idle();
    tick();

    // DIP_EN low: registers still update, outputs forced off until DIP_EN rises
    dip_en = 1'b0;
    io_write(16'h7F00, 8'hC2);
    chk("dip.cfg", 32'(cfg2), 32'h2);
    adr = 16'h0000; mreq_b = 1'b0; rd_b = 1'b0;
    #1;
    chk_idle2("dip.off");
    dip_en = 1'b1;
    #1;
    chk("dip.on.cs", 32'(bus2.ramcs_b), 32'h2);
    chk("dip.on.dis", 32'(bus2.ramdis), 32'h1);
    chk("dip.on.oe", 32'(bus2.ramoe_b), 32'h0);
    mem_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
